// File: rtl/cpu_pkg.sv
// Shared opcode, state and ALU-control definitions for the hardwired control unit.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_HALT = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        CLS_BINARY,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    localparam int ALU_INCPC = 0;
    localparam int ALU_ADD   = 1;
    localparam int ALU_SUB   = 2;
    localparam int ALU_AND   = 3;
    localparam int ALU_OR    = 4;
    localparam int ALU_SHR   = 5;
    localparam int ALU_SHRA  = 6;
    localparam int ALU_SHL   = 7;
    localparam int ALU_ROR   = 8;
    localparam int ALU_ROL   = 9;
    localparam int ALU_NEG   = 10;
    localparam int ALU_NOT   = 11;
    localparam int ALU_MUL   = 12;
    localparam int ALU_DIV   = 13;

    // Group opcodes by the shape of their execute sequence.
    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  op_class = CLS_BINARY;
            OP_NEG, OP_NOT:                   op_class = CLS_UNARY;
            OP_MUL, OP_DIV:                   op_class = CLS_MULDIV;
            OP_NOP:                           op_class = CLS_NOP;
            OP_HALT:                          op_class = CLS_HALT;
            default:                          op_class = CLS_ILLEGAL;
        endcase
    endfunction

    // ALU control bit selected by an opcode; IncPC for anything without an ALU op.
    function automatic logic [3:0] alu_index(input logic [4:0] op);
        case (op)
            OP_ADD:  alu_index = 4'(ALU_ADD);
            OP_SUB:  alu_index = 4'(ALU_SUB);
            OP_AND:  alu_index = 4'(ALU_AND);
            OP_OR:   alu_index = 4'(ALU_OR);
            OP_SHR:  alu_index = 4'(ALU_SHR);
            OP_SHRA: alu_index = 4'(ALU_SHRA);
            OP_SHL:  alu_index = 4'(ALU_SHL);
            OP_ROR:  alu_index = 4'(ALU_ROR);
            OP_ROL:  alu_index = 4'(ALU_ROL);
            OP_NEG:  alu_index = 4'(ALU_NEG);
            OP_NOT:  alu_index = 4'(ALU_NOT);
            OP_MUL:  alu_index = 4'(ALU_MUL);
            OP_DIV:  alu_index = 4'(ALU_DIV);
            default: alu_index = 4'(ALU_INCPC);
        endcase
    endfunction

endpackage

// File: rtl/reg_select.sv
// 4-to-N one-hot register strobe decoder with enable.
module reg_select #(
    parameter int N = 16
) (
    input  logic         en,
    input  logic [3:0]   sel,
    output logic [N-1:0] onehot
);

    // Drive the selected register strobe only while enabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) and execute (T3-T6) strobe sequencing.
//
// state | meaning
// ------+----------------------------------------------------------------
// T0    | PC -> MAR, Z <= PC+1; silent while stalled waiting for run
// T1    | Z -> PC, memory read into MDR
// T2    | MDR -> IR
// T3    | first execute step (operand fetch / unary op / NOP / dispatch)
// T4    | ALU op (binary, mul/div) or unary write-back
// T5    | binary write-back, or LO write for mul/div
// T6    | HI write for mul/div
// HALT  | all strobes off, halted=1 until clear
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int ALU_W = 14
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              run,
    input  logic [31:0]       IR,
    output logic [NREGS-1:0]  Rin,
    output logic [NREGS-1:0]  Rout,
    output logic              PCout,
    output logic              PCin,
    output logic              IRin,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              Yin,
    output logic              Zin,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              HIin,
    output logic              LOin,
    output logic              Read,
    output logic [ALU_W-1:0]  alu_ctl,
    output logic              halted,
    output logic              illegal,
    output logic [3:0]        state
);

    state_t     state_q, state_d;
    logic       stall_q;
    logic       illegal_q;
    op_class_t  cls;
    logic [3:0] alu_idx;
    logic [3:0] ra, rb, rc;
    logic       rin_en, rout_en;
    logic [3:0] rin_sel, rout_sel;
    logic       unused_ir;

    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign cls       = op_class(IR[31:27]);
    assign alu_idx   = alu_index(IR[31:27]);
    assign unused_ir = ^IR[14:0];

    // stall_q marks a T0 cycle entered from a T0 in which run was low; those
    // cycles issue no strobes so the held-off fetch has no side effects.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= ST_T0;
            stall_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= (state_q == ST_T0) && !run;
            if (state_q == ST_T3 && cls == CLS_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode from the state register and IR.
    always_comb begin
        state_d  = state_q;
        rin_en   = 1'b0;
        rin_sel  = ra;
        rout_en  = 1'b0;
        rout_sel = rb;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Read     = 1'b0;
        alu_ctl  = '0;
        halted   = 1'b0;
        case (state_q)
            ST_T0: begin
                if (!stall_q) begin
                    PCout              = 1'b1;
                    MARin              = 1'b1;
                    Zin                = 1'b1;
                    alu_ctl[ALU_INCPC] = 1'b1;
                end
                if (run) state_d = ST_T1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = ST_T2;
            end
            ST_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = ST_T3;
            end
            ST_T3: begin
                case (cls)
                    CLS_BINARY: begin
                        rout_en = 1'b1;
                        Yin     = 1'b1;
                        state_d = ST_T4;
                    end
                    CLS_UNARY: begin
                        rout_en = 1'b1;
                        alu_ctl = ALU_W'(1) << alu_idx;
                        Zin     = 1'b1;
                        state_d = ST_T4;
                    end
                    CLS_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        Yin      = 1'b1;
                        state_d  = ST_T4;
                    end
                    CLS_NOP:  state_d = ST_T0;
                    default:  state_d = ST_HALT;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_BINARY: begin
                        rout_en  = 1'b1;
                        rout_sel = rc;
                        alu_ctl  = ALU_W'(1) << alu_idx;
                        Zin      = 1'b1;
                        state_d  = ST_T5;
                    end
                    CLS_UNARY: begin
                        Zlowout = 1'b1;
                        rin_en  = 1'b1;
                        state_d = ST_T0;
                    end
                    CLS_MULDIV: begin
                        rout_en = 1'b1;
                        alu_ctl = ALU_W'(1) << alu_idx;
                        Zin     = 1'b1;
                        state_d = ST_T5;
                    end
                    default: state_d = ST_T0;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_BINARY: begin
                        Zlowout = 1'b1;
                        rin_en  = 1'b1;
                        state_d = ST_T0;
                    end
                    CLS_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                        state_d = ST_T6;
                    end
                    default: state_d = ST_T0;
                endcase
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = ST_T0;
            end
            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end
            default: state_d = ST_T0;
        endcase
    end

    reg_select #(.N(NREGS)) u_rin_sel (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (Rin)
    );

    reg_select #(.N(NREGS)) u_rout_sel (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (Rout)
    );

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that sits on the datapath control bus and produces, cycle by cycle, the register, bus, ALU and memory strobes that the datapath consumes. Implements a Moore state machine covering instruction fetch (T0–T2) and execute (T3–T6) for register-register ALU, unary (NEG/NOT), MUL/DIV and HALT instructions. Decodes the instruction fields from `IR` to select source and destination registers.

## Interface
Parameters:
- `NREGS`, 16, number of general registers; sets the width of `Rin` and `Rout`.
- `ALU_W`, 14, width of the one-hot ALU control vector.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `run`  in  1  permits a new fetch; sampled only in T0.
- `IR`  in  32  instruction register contents. Fields:
  - `[31:27]` opcode
  - `[26:23]` Ra (destination)
  - `[22:19]` Rb (source 1)
  - `[18:15]` Rc (source 2)
- `Rin`  out  NREGS  one-hot; bit i drives R{i}in.
- `Rout`  out  NREGS  one-hot; bit i drives R{i}out.
- `PCout, PCin, IRin, MARin, MDRin, MDRout, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read`  out  1 each  datapath strobes.
- `alu_ctl`  out  ALU_W  one-hot, bits 0..13 = IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV.
- `halted`  out  1  high while in HALT.
- `illegal`  out  1  sticky; set on an undefined opcode.
- `state`  out  4  current state encoding, for debug.

## Operation
States are T0, T1, T2, T3, T4, T5, T6 and HALT. Outputs decode combinationally from the state register and `IR` only; `run` and `clear` do not feed the outputs.

- **T0:** `PCout`, `MARin`, `alu_ctl[IncPC]`, `Zin`.
  - Next state is T1 if `run`=1.
  - Otherwise stay in T0 with all strobes 0 (stall; PC is not incremented).
- **T1:** `Zlowout`, `PCin`, `Read`, `MDRin`. Next is T2.
- **T2:** `MDRout`, `IRin`. Next is T3. Decode in T3 onward uses the `IR` value latched at the end of T2.
- **Binary ALU ops** (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL):
  - T3: `Rout[Rb]`, `Yin`.
  - T4: `Rout[Rc]`, `alu_ctl[op]`, `Zin`.
  - T5: `Zlowout`, `Rin[Ra]`. Then T0.
- **NEG / NOT:**
  - T3: `Rout[Rb]`, `alu_ctl[op]`, `Zin`.
  - T4: `Zlowout`, `Rin[Ra]`. Then T0.
- **MUL / DIV:**
  - T3: `Rout[Ra]`, `Yin`.
  - T4: `Rout[Rb]`, `alu_ctl[op]`, `Zin`.
  - T5: `Zlowout`, `LOin`.
  - T6: `Zhighout`, `HIin`. Then T0.
- **NOP:** T3 has all strobes 0. Then T0.
- **HALT opcode:** T3 goes to HALT. HALT holds all strobes at 0 and `halted`=1 until `clear`.
- **Undefined opcode:** T3 sets `illegal` and goes to HALT.
- **Strobe exclusivity:** at most one bus driver (`Rout` bit, `PCout`, `MDRout`, `Zlowout`, `Zhighout`) is active in any state. `Rin` and `Rout` are never both non-zero.

## Timing
- **Reset:** `clear`=1 at a rising edge puts the state in T0 and clears `illegal` on that edge. This holds from any state, including mid-instruction and HALT. No partial write-back strobe is issued afterwards.
- **Output values from the edge after `clear`=1:**
  - `state` = T0.
  - `halted` = 0, `illegal` = 0.
  - The T0 strobes are asserted (`PCout`, `MARin`, `alu_ctl[IncPC]`, `Zin`).
  - Every other strobe, `Rin`, `Rout` and the rest of `alu_ctl` are 0.
- **Instruction length** (from entering T0 to the next T0, with `run` high):
  - Binary ALU: 6 cycles.
  - NEG/NOT: 5 cycles.
  - MUL/DIV: 7 cycles.
  - NOP: 4 cycles.
- **Strobe validity:** strobes are valid for the whole state cycle. The datapath captures them on the rising edge that ends the state.
- **Memory:** the read is single-cycle. Data presented during T1 is captured into MDR at the end of T1. There is no wait state.
- **`run`:** only T0 observes it. Dropping `run` mid-instruction does not stop that instruction.

## Structure
- Package `cpu_pkg` holds:
  - 5-bit opcode constants: ADD=00011, SUB=00100, AND=00101, OR=00110, ROR=00111, ROL=01000, SHR=01001, SHRA=01010, SHL=01011, DIV=01111, MUL=10000, NEG=10001, NOT=10010, NOP=11010, HALT=11011.
  - The state encoding: T0..T6 = 0..6, HALT = 15.
  - The `alu_ctl` bit indices.
- Sub-module `reg_select`: combinational 4-to-16 one-hot decoder with an enable, instantiated for `Rin` and `Rout`.

## Test plan
- **NEG:** `IR` = NEG R4,R7 (opcode 10001, Ra=4, Rb=7), `run`=1.
  - T3: `Rout`=0x0080, `alu_ctl[NEG]`, `Zin`.
  - T4: `Zlowout`, `Rin`=0x0010.
  - Back in T0 five cycles after the first T0.
- **ADD:** `IR` = ADD R2,R5,R6.
  - T3: `Rout`=0x0020, `Yin`.
  - T4: `Rout`=0x0040, `alu_ctl[ADD]`.
  - T5: `Rin`=0x0004.
  - 6-cycle instruction.
- **MUL:** `IR` = MUL R3,R1.
  - T5: `LOin` with `Zlowout`.
  - T6: `HIin` with `Zhighout`.
  - `Rin` stays 0 throughout.
  - 7-cycle instruction.
- **Stall:** hold `run`=0 for 3 cycles.
  - `state` stays T0 with no strobes.
  - Raising `run` gives T1 on the next edge.
- **Opcode 11111:** `illegal`=1 and `halted`=1 after T3; stays halted.
  - `clear` pulse: T0 with `illegal`=0.
- **Clear mid-instruction:** assert `clear` in T4 of an ADD.
  - Next cycle is T0.
  - `Rin` is never non-zero after that edge.
